// File: rtl/bus_arbiter_2.sv
// ============================================================================
// Module   : bus_arbiter_2
// Purpose  : Two-host to one-bus arbiter. It latches a grant to one requester
//            and forwards that requester's transaction unchanged to the shared
//            bus. Completion goes back only to the owner. The bus is released
//            after each transfer. A watchdog aborts transfers that the device
//            never acknowledges.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT_CYCLES  watchdog limit in GRANT cycles without bus_ready
//                   (0 disables the watchdog, max 65535)
// Build option
//   BUS_ARB_ROUND_ROBIN_EN  defined   : ties go to the host that was not
//                                       granted last
//                           undefined : ties always go to host 0
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   hN_address/data_write/write_mask/ren/wen   requester N transaction in
//   hN_data_read/ready    requester N completion out (owner only)
//   bus_address/data_write/write_mask/ren/wen  shared bus transaction out
//   bus_data_read/ready   shared bus completion in
//   timeout_err           sticky watchdog-abort flag, cleared by reset only
// ============================================================================
`default_nettype none

module bus_arbiter_2 #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  // host 0
  input  logic [31:0] h0_address,
  input  logic [31:0] h0_data_write,
  input  logic [3:0]  h0_write_mask,
  input  logic        h0_ren,
  input  logic        h0_wen,
  output logic [31:0] h0_data_read,
  output logic        h0_ready,
  // host 1
  input  logic [31:0] h1_address,
  input  logic [31:0] h1_data_write,
  input  logic [3:0]  h1_write_mask,
  input  logic        h1_ren,
  input  logic        h1_wen,
  output logic [31:0] h1_data_read,
  output logic        h1_ready,
  // shared bus
  output logic [31:0] bus_address,
  output logic [31:0] bus_data_write,
  output logic [3:0]  bus_write_mask,
  output logic        bus_ren,
  output logic        bus_wen,
  input  logic [31:0] bus_data_read,
  input  logic        bus_ready,
  // status
  output logic        timeout_err
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam bit          WD_EN      = (TIMEOUT_CYCLES != 0);
  // Last count value before the abort fires; abort lands T+TIMEOUT_CYCLES.
  localparam logic [15:0] WD_LAST    = WD_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;
  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_err_q, timeout_err_d;

  logic        req0, req1;
  logic        winner;
  logic        granted;
  logic        sel_req;
  logic        done_ok;
  logic        wd_abort;
  logic        ret;
  logic [31:0] ret_data;

  assign req0 = h0_ren | h0_wen;
  assign req1 = h1_ren | h1_wen;

  // --------------------------------------------------------------------------
  // Arbitration: a single requester always wins; only ties use the policy.
  // --------------------------------------------------------------------------
`ifdef BUS_ARB_ROUND_ROBIN_EN
  always_comb begin
    winner = req1;
    if (req0 && req1) begin
      // last_grant resets to 1 so the first tie after reset goes to host 0.
      winner = ~last_grant_q;
    end
  end
`else
  // last_grant is still tracked so both builds share one state model.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;

  always_comb begin
    winner = req1;
    if (req0 && req1) begin
      winner = 1'b0;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Completion decode for the current owner
  // --------------------------------------------------------------------------
  assign granted  = (state_q == ST_GRANT);
  assign sel_req  = grant_q ? req1 : req0;
  assign done_ok  = granted & sel_req & bus_ready;
  // A real ready in the limit cycle wins over the abort.
  assign wd_abort = WD_EN & granted & sel_req & ~bus_ready & (wd_cnt_q == WD_LAST);
  assign ret      = done_ok | wd_abort;
  assign ret_data = wd_abort ? ABORT_DATA : bus_data_read;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant_d  = winner;
          wd_cnt_d = 16'd0;
          state_d  = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (!sel_req) begin
          // Owner withdrew: release silently, fairness history untouched.
          state_d = ST_IDLE;
        end else if (bus_ready) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end else if (wd_abort) begin
          last_grant_d  = grant_q;
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      wd_cnt_q      <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output muxes: purely combinational from the registered grant, so bus
  // requests and completions pass through with no added latency.
  // --------------------------------------------------------------------------
  always_comb begin
    bus_address    = 32'd0;
    bus_data_write = 32'd0;
    bus_write_mask = 4'd0;
    bus_ren        = 1'b0;
    bus_wen        = 1'b0;
    if (granted) begin
      if (grant_q) begin
        bus_address    = h1_address;
        bus_data_write = h1_data_write;
        bus_write_mask = h1_write_mask;
        bus_ren        = h1_ren;
        bus_wen        = h1_wen;
      end else begin
        bus_address    = h0_address;
        bus_data_write = h0_data_write;
        bus_write_mask = h0_write_mask;
        bus_ren        = h0_ren;
        bus_wen        = h0_wen;
      end
    end
  end

  always_comb begin
    h0_ready     = 1'b0;
    h0_data_read = 32'd0;
    h1_ready     = 1'b0;
    h1_data_read = 32'd0;
    if (ret) begin
      if (grant_q) begin
        h1_ready     = 1'b1;
        h1_data_read = ret_data;
      end else begin
        h0_ready     = 1'b1;
        h0_data_read = ret_data;
      end
    end
  end

  assign timeout_err = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_2.sv
`default_nettype none

module tb_bus_arbiter_2;

  logic        clk;
  logic        rst_n;
  logic [31:0] h0_address, h0_data_write, h0_data_read;
  logic [3:0]  h0_write_mask;
  logic        h0_ren, h0_wen, h0_ready;
  logic [31:0] h1_address, h1_data_write, h1_data_read;
  logic [3:0]  h1_write_mask;
  logic        h1_ren, h1_wen, h1_ready;
  logic [31:0] bus_address, bus_data_write, bus_data_read;
  logic [3:0]  bus_write_mask;
  logic        bus_ren, bus_wen, bus_ready;
  logic        timeout_err;

  bus_arbiter_2 #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .h0_address(h0_address), .h0_data_write(h0_data_write),
    .h0_write_mask(h0_write_mask), .h0_ren(h0_ren), .h0_wen(h0_wen),
    .h0_data_read(h0_data_read), .h0_ready(h0_ready),
    .h1_address(h1_address), .h1_data_write(h1_data_write),
    .h1_write_mask(h1_write_mask), .h1_ren(h1_ren), .h1_wen(h1_wen),
    .h1_data_read(h1_data_read), .h1_ready(h1_ready),
    .bus_address(bus_address), .bus_data_write(bus_data_write),
    .bus_write_mask(bus_write_mask), .bus_ren(bus_ren), .bus_wen(bus_wen),
    .bus_data_read(bus_data_read), .bus_ready(bus_ready),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic        host;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push(input logic host, input logic [31:0] data);
    exp_t e;
    e.host = host;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard: every ready must match the oldest expected completion.
  always @(negedge clk) begin
    if (h0_ready || h1_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_ready", {30'd0, h1_ready, h0_ready}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_ready_host", {30'd0, h1_ready, h0_ready}, e.host ? 32'd2 : 32'd1);
        check("sb_data", e.host ? h1_data_read : h0_data_read, e.data);
        check("sb_other_data_zero", e.host ? h0_data_read : h1_data_read, 32'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    h0_address = '0; h0_data_write = '0; h0_write_mask = '0; h0_ren = 0; h0_wen = 0;
    h1_address = '0; h1_data_write = '0; h1_write_mask = '0; h1_ren = 0; h1_wen = 0;
    bus_data_read = '0; bus_ready = 1'b0;

    // ---------------- reset state ----------------
    sample();
    check("rst_flags", {27'd0, bus_ren, bus_wen, h0_ready, h1_ready, timeout_err}, 32'd0);
    check("rst_bus_addr", bus_address, 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // ---------------- host 0 read, zero-wait device ----------------
    bus_ready = 1'b1; bus_data_read = 32'h12345678;
    h0_address = 32'h1000; h0_ren = 1'b1;
    push(1'b0, 32'h12345678);
    sample();
    check("t1_idle_ren", {31'd0, bus_ren}, 32'd0);
    next_cycle();
    sample();
    check("t1_bus_ren", {31'd0, bus_ren}, 32'd1);
    check("t1_bus_addr", bus_address, 32'h1000);
    check("t1_h0_ready", {31'd0, h0_ready}, 32'd1);
    check("t1_h1_ready", {31'd0, h1_ready}, 32'd0);
    next_cycle();
    h0_ren = 1'b0;
    sample();
    check("t1_released", {30'd0, bus_ren, h0_ready}, 32'd0);

    // ---------------- both hosts continuous ----------------
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    bus_data_read = 32'hA5A50000;
    h0_address = 32'h100; h0_ren = 1'b1;
    h1_address = 32'h200; h1_data_write = 32'h11112222; h1_write_mask = 4'hF; h1_wen = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic eh;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      eh = k[0];
`else
      eh = 1'b0;
`endif
      push(eh, 32'hA5A50000);
      sample();
      check("t2_idle_strobes", {30'd0, bus_ren, bus_wen}, 32'd0);
      next_cycle();
      sample();
      check("t2_grant_addr", bus_address, eh ? 32'h200 : 32'h100);
      check("t2_grant_strobes", {30'd0, bus_ren, bus_wen}, eh ? 32'd1 : 32'd2);
      next_cycle();
    end
    // host 0 drops; host 1 must now be served
    h0_ren = 1'b0;
    push(1'b1, 32'hA5A50000);
    sample();
    next_cycle();
    sample();
    check("t2_h1_after_drop", {31'd0, bus_wen}, 32'd1);
    check("t2_h1_addr", bus_address, 32'h200);
    next_cycle();
    h1_wen = 1'b0;

    // ---------------- host 1 write with 3 wait cycles ----------------
    bus_ready = 1'b0; bus_data_read = 32'h55AA55AA;
    h1_address = 32'h2000; h1_data_write = 32'hCAFEBABE; h1_write_mask = 4'b0011; h1_wen = 1'b1;
    push(1'b1, 32'h55AA55AA);
    sample();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 3) bus_ready = 1'b1;
      sample();
      check("t3_wen", {31'd0, bus_wen}, 32'd1);
      check("t3_addr", bus_address, 32'h2000);
      check("t3_wdata", bus_data_write, 32'hCAFEBABE);
      check("t3_mask", {28'd0, bus_write_mask}, 32'h3);
      check("t3_h1_ready", {31'd0, h1_ready}, (i == 3) ? 32'd1 : 32'd0);
    end
    next_cycle();
    h1_wen = 1'b0; bus_ready = 1'b0;

    // ---------------- watchdog abort ----------------
    h0_address = 32'h3000; h0_ren = 1'b1;
    push(1'b0, 32'hDEADBEEF);
    sample();
    for (int i = 1; i <= 8; i++) begin
      next_cycle();
      sample();
      check("t4_h0_ready", {31'd0, h0_ready}, (i == 8) ? 32'd1 : 32'd0);
      check("t4_err_before", {31'd0, timeout_err}, 32'd0);
    end
    next_cycle();
    h0_ren = 1'b0;
    sample();
    check("t4_err_set", {31'd0, timeout_err}, 32'd1);
    // a good transfer afterwards must not clear the flag
    bus_ready = 1'b1; bus_data_read = 32'h0BADF00D;
    h1_address = 32'h3100; h1_ren = 1'b1;
    push(1'b1, 32'h0BADF00D);
    next_cycle();
    sample();
    check("t4_good_ready", {31'd0, h1_ready}, 32'd1);
    next_cycle();
    h1_ren = 1'b0; bus_ready = 1'b0;
    sample();
    check("t4_err_sticky", {31'd0, timeout_err}, 32'd1);

    // ---------------- granted host withdraws ----------------
    h0_address = 32'h5000; h0_ren = 1'b1;
    next_cycle();
    h1_address = 32'h4000; h1_ren = 1'b1;
    sample();
    check("t5_grant0", bus_address, 32'h5000);
    next_cycle();
    h0_ren = 1'b0;
    sample();
    check("t5_withdrawn", {28'd0, bus_ren, bus_wen, h0_ready, h1_ready}, 32'd0);
    next_cycle();
    sample();
    check("t5_idle", {31'd0, bus_ren}, 32'd0);
    next_cycle();
    bus_ready = 1'b1; bus_data_read = 32'h77778888;
    push(1'b1, 32'h77778888);
    sample();
    check("t5_grant1_addr", bus_address, 32'h4000);
    check("t5_grant1_ren", {31'd0, bus_ren}, 32'd1);
    next_cycle();
    h1_ren = 1'b0; bus_ready = 1'b0;

    // ---------------- reset mid-wait ----------------
    h1_address = 32'h6000; h1_ren = 1'b1;
    next_cycle();
    next_cycle();
    sample();
    check("t6_waiting", {31'd0, bus_ren}, 32'd1);
    check("t6_err_before", {31'd0, timeout_err}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_async_flags", {27'd0, bus_ren, bus_wen, h0_ready, h1_ready, timeout_err}, 32'd0);
    check("t6_async_addr", bus_address, 32'd0);
    check("t6_async_data", h1_data_read, 32'd0);
    next_cycle();
    h1_ren = 1'b0;
    rst_n = 1'b1;
    sample();
    check("t6_after", {27'd0, bus_ren, bus_wen, h0_ready, h1_ready, timeout_err}, 32'd0);
    next_cycle();

    check("sb_drain", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
